shield_ctl: RTL and testbench

Power-up shield controller that sits directly upstream of the game FSM and drives its is_shielded input. Runs a pickup/active/cooldown cycle counted in video frames. When Donkey touches the shield pickup, the controller grants a timed shield. It also produces draw-enable signals for the pickup sprite and the shield overlay, with a warning blink near expiry.

---
 rtl/shield_ctl.sv | 162 ++++++++++++++++
 tb/tb_shield_ctl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shield_ctl.sv
// Power-up shield controller: pickup -> timed shield -> cooldown cycle, counted in video frames.
// Latency: every output is registered and changes on the same edge as the state change behind it.
// Backpressure: none; frame_tick/pickup_touch/barrel_hit are sampled every cycle.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   game_en         game running; low forces ST_IDLE and clears everything
//   frame_tick      one-cycle pulse per video frame
//   pickup_touch    Donkey overlaps the pickup sprite (level)
//   barrel_hit      per-barrel hit vector (used only when SHIELD_BREAK_EN is defined)
//   is_shielded     shield active, to the game FSM
//   shield_visible  overlay draw enable (blinks during the final BLINK_FRAMES)
//   pickup_visible  pickup sprite draw enable
//   shield_granted  one-cycle pulse when a shield starts
//   frames_left     remaining frames in ACTIVE/COOLDOWN, else 0
//
// Build option: define SHIELD_BREAK_EN so that any barrel hit during an active
// shield ends it early and starts the cooldown.
module shield_ctl #(
  parameter int SHIELD_FRAMES   = 300,
  parameter int COOLDOWN_FRAMES = 180,
  parameter int BLINK_FRAMES    = 60,
  parameter int BLINK_PERIOD    = 8,
  localparam int CW = $clog2(((SHIELD_FRAMES > COOLDOWN_FRAMES) ?
                              SHIELD_FRAMES : COOLDOWN_FRAMES) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_en,
  input  logic          frame_tick,
  input  logic          pickup_touch,
  input  logic [9:0]    barrel_hit,
  output logic          is_shielded,
  output logic          shield_visible,
  output logic          pickup_visible,
  output logic          shield_granted,
  output logic [CW-1:0] frames_left
);

  localparam int BW = $clog2(BLINK_PERIOD);

  localparam logic [CW-1:0] SHIELD_C = CW'(SHIELD_FRAMES);
  localparam logic [CW-1:0] COOL_C   = CW'(COOLDOWN_FRAMES);
  localparam logic [CW-1:0] BLINK_C  = CW'(BLINK_FRAMES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [BW-1:0] BLAST_C  = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BHALF_C  = BW'(BLINK_PERIOD / 2);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READY    = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] blink_cnt, blink_n;
  logic          break_hit;

  logic          shielded_n;
  logic          shield_vis_n;
  logic          pickup_vis_n;
  logic          granted_n;
  logic [CW-1:0] frames_left_n;

`ifdef SHIELD_BREAK_EN
  assign break_hit = |barrel_hit;
`else
  // Hits are absorbed silently; the shield always runs its full duration.
  logic unused_barrel_hit;
  assign unused_barrel_hit = |barrel_hit;
  assign break_hit = 1'b0;
`endif

  // Next-state / counter logic. game_en low overrides every other event.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    blink_n = blink_cnt;
    if (!game_en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      blink_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_COOLDOWN;
          cnt_n   = COOL_C;
        end
        ST_READY: begin
          // A tick in the same cycle as the touch is dropped: full duration.
          if (pickup_touch) begin
            state_n = ST_ACTIVE;
            cnt_n   = SHIELD_C;
            blink_n = '0;
          end
        end
        ST_ACTIVE: begin
          if (break_hit || (frame_tick && cnt == ONE_C)) begin
            state_n = ST_COOLDOWN;
            cnt_n   = COOL_C;
            blink_n = '0;
          end else if (frame_tick) begin
            cnt_n   = cnt - ONE_C;
            blink_n = (blink_cnt == BLAST_C) ? '0 : blink_cnt + BW'(1);
          end
        end
        ST_COOLDOWN: begin
          if (frame_tick) begin
            if (cnt == ONE_C) begin
              state_n = ST_READY;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt - ONE_C;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          blink_n = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next state so they register on the same edge.
  always_comb begin
    shielded_n    = (state_n == ST_ACTIVE);
    pickup_vis_n  = (state_n == ST_READY);
    granted_n     = game_en && (state == ST_READY) && pickup_touch;
    shield_vis_n  = shielded_n && ((cnt_n > BLINK_C) || (blink_n < BHALF_C));
    frames_left_n = '0;
    if (state_n == ST_ACTIVE || state_n == ST_COOLDOWN) begin
      frames_left_n = cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      blink_cnt      <= '0;
      is_shielded    <= 1'b0;
      shield_visible <= 1'b0;
      pickup_visible <= 1'b0;
      shield_granted <= 1'b0;
      frames_left    <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      blink_cnt      <= blink_n;
      is_shielded    <= shielded_n;
      shield_visible <= shield_vis_n;
      pickup_visible <= pickup_vis_n;
      shield_granted <= granted_n;
      frames_left    <= frames_left_n;
    end
  end

endmodule

// File: tb/tb_shield_ctl.sv
// Directed bench for shield_ctl with SHIELD_FRAMES=10, COOLDOWN_FRAMES=4,
// BLINK_FRAMES=4, BLINK_PERIOD=2. Table of per-cycle vectors plus a
// hand-written asynchronous-reset sequence.
module tb_shield_ctl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          game_en = 1'b0;
  logic          frame_tick = 1'b0;
  logic          pickup_touch = 1'b0;
  logic [9:0]    barrel_hit = '0;
  logic          is_shielded;
  logic          shield_visible;
  logic          pickup_visible;
  logic          shield_granted;
  logic [CW-1:0] frames_left;

  int n_cmp = 0;
  int n_bad = 0;

  shield_ctl #(
    .SHIELD_FRAMES(10),
    .COOLDOWN_FRAMES(4),
    .BLINK_FRAMES(4),
    .BLINK_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_en(game_en),
    .frame_tick(frame_tick),
    .pickup_touch(pickup_touch),
    .barrel_hit(barrel_hit),
    .is_shielded(is_shielded),
    .shield_visible(shield_visible),
    .pickup_visible(pickup_visible),
    .shield_granted(shield_granted),
    .frames_left(frames_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ge;
    logic       tk;
    logic       tc;
    logic [9:0] hit;
    logic       e_sh;
    logic       e_sv;
    logic       e_pv;
    logic       e_sg;
    logic [3:0] e_fl;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ge, input logic tk, input logic tc, input logic [9:0] hit,
                     input logic sh, input logic sv, input logic pv, input logic sg,
                     input logic [3:0] fl, input string name);
    vec_t v;
    v.ge = ge; v.tk = tk; v.tc = tc; v.hit = hit;
    v.e_sh = sh; v.e_sv = sv; v.e_pv = pv; v.e_sg = sg; v.e_fl = fl;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic sh, input logic sv, input logic pv,
                       input logic sg, input logic [3:0] fl);
    n_cmp++;
    if ({is_shielded, shield_visible, pickup_visible, shield_granted, frames_left} !==
        {sh, sv, pv, sg, fl}) begin
      n_bad++;
      $display("FAIL %s: got sh=%0b sv=%0b pv=%0b sg=%0b fl=%0d, want sh=%0b sv=%0b pv=%0b sg=%0b fl=%0d",
               name, is_shielded, shield_visible, pickup_visible, shield_granted, frames_left,
               sh, sv, pv, sg, fl);
    end
  endtask

  task automatic drive(input logic ge, input logic tk, input logic tc, input logic [9:0] hit);
    @(negedge clk);
    game_en = ge; frame_tick = tk; pickup_touch = tc; barrel_hit = hit;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  ge tk tc hit     sh sv pv sg fl
    // Start sequence
    add(1, 0, 0, 10'h0, 0, 0, 0, 0, 4,  "start_load");
    add(1, 0, 0, 10'h0, 0, 0, 0, 0, 4,  "cool_hold");
    add(1, 1, 0, 10'h0, 0, 0, 0, 0, 3,  "cool_3");
    add(1, 1, 0, 10'h0, 0, 0, 0, 0, 2,  "cool_2");
    add(1, 1, 0, 10'h0, 0, 0, 0, 0, 1,  "cool_1");
    add(1, 1, 0, 10'h0, 0, 0, 1, 0, 0,  "ready");
    add(1, 0, 0, 10'h0, 0, 0, 1, 0, 0,  "ready_hold");
    // Grant, touch held afterwards
    add(1, 0, 1, 10'h0, 1, 1, 0, 1, 10, "grant");
    add(1, 0, 1, 10'h0, 1, 1, 0, 0, 10, "grant_pulse_end");
    add(1, 0, 1, 10'h0, 1, 1, 0, 0, 10, "touch_held");
    // Expiry and blink
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 9,  "act_9");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 8,  "act_8");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 7,  "act_7");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 6,  "act_6");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 5,  "act_5");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 4,  "blink_4_on");
    add(1, 1, 0, 10'h0, 1, 0, 0, 0, 3,  "blink_3_off");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 2,  "blink_2_on");
    add(1, 1, 0, 10'h0, 1, 0, 0, 0, 1,  "blink_1_off");
    add(1, 1, 0, 10'h0, 0, 0, 0, 0, 4,  "expire");
    add(1, 0, 1, 10'h0, 0, 0, 0, 0, 4,  "cool_touch_ignored");
    add(1, 1, 0, 10'h0, 0, 0, 0, 0, 3,  "cool2_3");
    add(1, 1, 0, 10'h0, 0, 0, 0, 0, 2,  "cool2_2");
    add(1, 1, 0, 10'h0, 0, 0, 0, 0, 1,  "cool2_1");
    add(1, 1, 0, 10'h0, 0, 0, 1, 0, 0,  "ready2");
    // Touch and tick together: full duration, tick dropped
    add(1, 1, 1, 10'h0, 1, 1, 0, 1, 10, "touch_tick");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 9,  "act2_9");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 8,  "act2_8");
    add(1, 1, 0, 10'h0, 1, 1, 0, 0, 7,  "act2_7");
    // Barrel hit at frames_left=7
`ifdef SHIELD_BREAK_EN
    add(1, 0, 0, 10'h004, 0, 0, 0, 0, 4, "hit_break");
    add(1, 1, 0, 10'h0,   0, 0, 0, 0, 3, "after_break");
`else
    add(1, 0, 0, 10'h004, 1, 1, 0, 0, 7, "hit_absorbed");
    add(1, 1, 0, 10'h0,   1, 1, 0, 0, 6, "after_hit");
`endif
    // Abort with a coincident tick (frames_left=6 in the default build)
    add(0, 1, 0, 10'h0, 0, 0, 0, 0, 0,  "abort");
    add(0, 1, 1, 10'h0, 0, 0, 0, 0, 0,  "idle_stays");

    // Reset state
    #12;
    check("reset_state", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ge, vecs[i].tk, vecs[i].tc, vecs[i].hit);
      check(vecs[i].name, vecs[i].e_sh, vecs[i].e_sv, vecs[i].e_pv, vecs[i].e_sg, vecs[i].e_fl);
    end

    // Asynchronous reset in the middle of an active shield
    drive(1, 0, 0, 10'h0);
    for (int k = 0; k < 4; k++) drive(1, 1, 0, 10'h0);
    check("async_ready", 0, 0, 1, 0, 0);
    drive(1, 0, 1, 10'h0);
    drive(1, 1, 0, 10'h0);
    check("async_active", 1, 1, 0, 0, 9);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_drop", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    game_en = 1'b0;
    frame_tick = 1'b0;
    drive(0, 0, 0, 10'h0);
    check("post_reset_idle", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 10'h0);
    check("restart_load", 0, 0, 0, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
